// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the ID/EX register and the iterative RV32M
// multiply/divide unit in the EX stage.
interface ex_muldiv_if #(
    parameter int WordSize = 32
);
    // Handshake: start is taken only when the unit is idle and flush is low.
    // There is no ready signal and no queuing. busy stays high while the unit
    // iterates. done is a one-cycle valid pulse with no backpressure, and
    // result/rdn hold their values until the next done.
    logic                start;
    logic [2:0]          op;
    logic [WordSize-1:0] a;
    logic [WordSize-1:0] b;
    logic [4:0]          rdn_in;
    logic                flush;
    logic                busy;
    logic                done;
    logic [WordSize-1:0] result;
    logic [4:0]          rdn;

    modport master (
        output start, op, a, b, rdn_in, flush,
        input  busy, done, result, rdn
    );

    modport slave (
        input  start, op, a, b, rdn_in, flush,
        output busy, done, result, rdn
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with the sign fixed up after the last iteration.
module ex_muldiv #(
    parameter int WordSize = 32
) (
    input  logic        clk,
    input  logic        rstn,
    ex_muldiv_if.slave  bus,
    output logic [1:0]  dbg_state
);
    localparam int CntW = $clog2(WordSize);
    localparam logic [WordSize-1:0] MinInt = {1'b1, {(WordSize-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]          op_q;
    logic [4:0]          rdn_cap;
    logic                neg_q;
    logic                spec_q;
    logic [CntW-1:0]     cnt_q;
    logic [WordSize-1:0] hi_q;
    logic [WordSize-1:0] lo_q;
    logic [WordSize-1:0] opnd_q;
    logic [WordSize-1:0] result_q;
    logic [4:0]          rdn_q;
    logic                done_q;

    logic                a_signed, b_signed, sa, sb, is_div;
    logic [WordSize-1:0] a_mag, b_mag, special_res;
    logic                div_zero, div_ovf, special, launch_neg, launch;

    logic [WordSize:0]     mul_sum, div_shift, div_diff;
    logic [WordSize-1:0]   iter_hi, iter_lo;
    logic [2*WordSize-1:0] prod_abs, prod_signed;
    logic [WordSize-1:0]   quot, rem, fin_val;

    // Launch decode: signedness, magnitudes and the cases that skip iteration.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.op)
            3'd1, 3'd4, 3'd6: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'd2:    a_signed = 1'b1;
            default: ;
        endcase
        sa       = a_signed & bus.a[WordSize-1];
        sb       = b_signed & bus.b[WordSize-1];
        a_mag    = sa ? -bus.a : bus.a;
        b_mag    = sb ? -bus.b : bus.b;
        is_div   = bus.op[2];
        div_zero = is_div && (bus.b == '0);
        div_ovf  = is_div && !bus.op[0] && (bus.a == MinInt) && (bus.b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = bus.op[1] ? bus.a : '1;
        end else begin
            special_res = bus.op[1] ? '0 : bus.a;
        end
        // Remainder takes the dividend's sign; everything else takes sa^sb.
        launch_neg = (is_div && bus.op[1]) ? sa : (sa ^ sb);
    end

    // One iteration step. hi_q is the upper product half or the partial
    // remainder; lo_q is the multiplier/lower product or the dividend/quotient.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[WordSize-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            iter_hi = div_diff[WordSize] ? div_shift[WordSize-1:0] : div_diff[WordSize-1:0];
            iter_lo = {lo_q[WordSize-2:0], ~div_diff[WordSize]};
        end else begin
            iter_hi = mul_sum[WordSize:1];
            iter_lo = {mul_sum[0], lo_q[WordSize-1:1]};
        end
    end

    // Sign fix-up and selection of the returned word.
    always_comb begin
        prod_abs    = {hi_q, lo_q};
        prod_signed = neg_q ? -prod_abs : prod_abs;
        quot        = neg_q ? -lo_q : lo_q;
        rem         = neg_q ? -hi_q : hi_q;
        case (op_q)
            3'd0:             fin_val = prod_signed[WordSize-1:0];
            3'd1, 3'd2, 3'd3: fin_val = prod_signed[2*WordSize-1:WordSize];
            3'd4, 3'd5:       fin_val = quot;
            default:          fin_val = rem;
        endcase
        if (spec_q) begin
            fin_val = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        launch  = 1'b1;
                        state_d = special ? S_FIN : S_CALC;
                    end
                end
                S_CALC: begin
                    if (cnt_q == CntW'(WordSize - 1)) begin
                        state_d = S_FIN;
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q     <= '0;
            rdn_cap  <= '0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            rdn_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (launch) begin
                op_q    <= bus.op;
                rdn_cap <= bus.rdn_in;
                neg_q   <= launch_neg;
                spec_q  <= special;
                cnt_q   <= '0;
                hi_q    <= '0;
                if (special) begin
                    lo_q <= special_res;
                end else if (bus.op[2]) begin
                    lo_q   <= a_mag;
                    opnd_q <= b_mag;
                end else begin
                    lo_q   <= b_mag;
                    opnd_q <= a_mag;
                end
            end else if (state_q == S_CALC && !bus.flush) begin
                hi_q  <= iter_hi;
                lo_q  <= iter_lo;
                cnt_q <= cnt_q + CntW'(1);
            end else if (state_q == S_FIN && !bus.flush) begin
                result_q <= fin_val;
                rdn_q    <= rdn_cap;
                done_q   <= 1'b1;
            end
        end
    end

    assign bus.busy   = (state_q == S_CALC);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rdn    = rdn_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a vector table of hand-computed results plus
// sequences for flush, ignored starts and asynchronous reset.
module tb_ex_muldiv;
    logic       clk;
    logic       rstn;
    logic [1:0] dbg_state;

    ex_muldiv_if #(.WordSize(32)) bus ();

    ex_muldiv #(.WordSize(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd  = '0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] rd,
                                    input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Drive one op; inj_at > 0 pulses a conflicting start that many cycles after launch.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat,
                          input int inj_at, input string name);
        int          cycles;
        logic        got;
        logic        seen_busy;
        logic [31:0] e;
        exp_q.push_back(exp);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.a      = a;
        bus.b      = b;
        bus.rdn_in = rd;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.a      = $urandom;
        bus.b      = $urandom;
        bus.op     = 3'($urandom_range(0, 7));
        bus.rdn_in = 5'($urandom_range(0, 31));
        check({name, "/busy_after_start"}, 32'(bus.busy), (lat > 1) ? 32'd1 : 32'd0);
        cycles    = 0;
        got       = 1'b0;
        seen_busy = bus.busy;
        while (cycles < 100 && !got) begin
            if (inj_at > 0 && cycles == inj_at) begin
                bus.start  = 1'b1;
                bus.op     = 3'd4;
                bus.a      = 32'd99;
                bus.b      = 32'd3;
                bus.rdn_in = 5'd20;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            if (bus.busy) seen_busy = 1'b1;
            got = bus.done;
        end
        bus.start = 1'b0;
        check({name, "/latency"}, 32'(cycles), 32'(lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({name, "/result"}, bus.result, e);
        check({name, "/rdn"}, 32'(bus.rdn), 32'(rd));
        if (lat == 1) check({name, "/busy_never"}, 32'(seen_busy), 32'd0);
        @(posedge clk); #1;
        check({name, "/done_pulse"}, 32'(bus.done), 32'd0);
        check({name, "/idle_after"}, 32'(bus.busy), 32'd0);
        last_res = exp;
        last_rd  = rd;
    endtask

    initial begin
        rstn       = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.op     = '0;
        bus.a      = '0;
        bus.b      = '0;
        bus.rdn_in = '0;

        add_vec(3'd0, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33);
        add_vec(3'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 33);
        add_vec(3'd3, 32'h80000000, 32'h80000000, 5'd5,  32'h40000000, 33);
        add_vec(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 33);
        add_vec(3'd4, 32'hFFFFFFEC, 32'd6,        5'd7,  32'hFFFFFFFD, 33);
        add_vec(3'd6, 32'hFFFFFFEC, 32'd6,        5'd8,  32'hFFFFFFFE, 33);
        add_vec(3'd5, 32'd20,       32'd6,        5'd9,  32'd3,        33);
        add_vec(3'd7, 32'd20,       32'd6,        5'd10, 32'd2,        33);
        add_vec(3'd4, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1);
        add_vec(3'd6, 32'd5,        32'd0,        5'd12, 32'd5,        1);
        add_vec(3'd5, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
        add_vec(3'd7, 32'd7,        32'd0,        5'd14, 32'd7,        1);
        add_vec(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
        add_vec(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1);
        add_vec(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'd1,        33);
        add_vec(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd18, 32'hFFFFFFFE, 33);
        add_vec(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd19, 32'd0,        33);
        add_vec(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd21, 32'h3FFFFFFF, 33);
        add_vec(3'd1, 32'hFFFFFFFE, 32'd3,        5'd22, 32'hFFFFFFFF, 33);
        add_vec(3'd2, 32'd2,        32'hFFFFFFFF, 5'd23, 32'd1,        33);
        add_vec(3'd4, 32'd7,        32'hFFFFFFFE, 5'd24, 32'hFFFFFFFD, 33);
        add_vec(3'd6, 32'd7,        32'hFFFFFFFE, 5'd25, 32'd1,        33);
        add_vec(3'd6, 32'hFFFFFFF9, 32'd2,        5'd26, 32'hFFFFFFFF, 33);
        add_vec(3'd5, 32'hFFFFFFFF, 32'd1,        5'd27, 32'hFFFFFFFF, 33);
        add_vec(3'd7, 32'hFFFFFFFF, 32'd10,       5'd28, 32'd5,        33);
        add_vec(3'd4, 32'h80000000, 32'd1,        5'd29, 32'h80000000, 33);
        add_vec(3'd6, 32'h80000000, 32'd3,        5'd30, 32'hFFFFFFFE, 33);
        add_vec(3'd7, 32'd3,        32'd7,        5'd31, 32'd3,        33);

        repeat (2) @(posedge clk);
        #1;
        check("reset/busy",   32'(bus.busy),   32'd0);
        check("reset/done",   32'(bus.done),   32'd0);
        check("reset/result", bus.result,      32'd0);
        check("reset/rdn",    32'(bus.rdn),    32'd0);
        check("reset/state",  32'(dbg_state),  32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp,
                   vecs[i].lat, 0, $sformatf("vec%0d", i));
        end

        // flush in the 10th CALC cycle, then relaunch immediately
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd7; bus.rdn_in = 5'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush/state",  32'(dbg_state), 32'd0);
        check("flush/busy",   32'(bus.busy),  32'd0);
        check("flush/done",   32'(bus.done),  32'd0);
        check("flush/result", bus.result,     last_res);
        check("flush/rdn",    32'(bus.rdn),   32'(last_rd));
        run_op(3'd5, 32'd100, 32'd7, 5'd10, 32'd14, 33, 0, "after_flush");

        // conflicting start during CALC and during FIN are both ignored
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 33, 5, "start_in_calc");
        run_op(3'd5, 32'd20, 32'd6, 5'd12, 32'd3, 33, 32, "start_in_fin");

        // flush wins over start in the same idle cycle
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start/state", 32'(dbg_state), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flush_start/done",   32'(bus.done), 32'd0);
        check("flush_start/result", bus.result,    last_res);

        // asynchronous reset in the middle of CALC
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'hFFFFFFFD; bus.rdn_in = 5'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midreset/busy_before", 32'(bus.busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("midreset/busy",   32'(bus.busy),  32'd0);
        check("midreset/done",   32'(bus.done),  32'd0);
        check("midreset/result", bus.result,     32'd0);
        check("midreset/rdn",    32'(bus.rdn),   32'd0);
        check("midreset/state",  32'(dbg_state), 32'd0);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        check("postreset/done", 32'(bus.done), 32'd0);
        run_op(3'd6, 32'hFFFFFFEC, 32'd6, 5'd8, 32'hFFFFFFFE, 33, 0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
